// File: rtl/ysyx_23060203_mem_arb.sv
// ysyx_23060203_mem_arb
//
// Arbitrates the single memory port between the fetch unit (IFU) and the
// load/store unit (LSU). A request is granted only in IDLE. Its fields are
// latched and presented to memory until the memory accepts them. The block then
// waits for the memory response and routes the response valid back to the
// owner. Only one transaction is outstanding at a time.
//
// Ports:
//   clk, rst            clock; synchronous active-high reset
//   ifu_req_*           IFU request channel (valid/ready, addr)
//   ifu_resp_*          IFU response (valid pulse, data)
//   lsu_req_*           LSU request channel (valid/ready, addr, wen, wdata, wmask)
//   lsu_resp_*          LSU response (valid pulse, data)
//   mem_req_*           latched request towards memory (valid/ready)
//   mem_resp_*          memory response (valid, data)
//   busy                high whenever the FSM is not IDLE
//
// Optional build macro:
//   MEM_ARB_RR_EN       if defined, ties are broken round-robin using a
//                       last_owner register. If undefined, the LSU always
//                       wins a tie.
module ysyx_23060203_mem_arb #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ifu_req_valid,
    output logic                ifu_req_ready,
    input  logic [ADDR_W-1:0]   ifu_req_addr,
    output logic                ifu_resp_valid,
    output logic [DATA_W-1:0]   ifu_resp_data,
    input  logic                lsu_req_valid,
    output logic                lsu_req_ready,
    input  logic [ADDR_W-1:0]   lsu_req_addr,
    input  logic                lsu_req_wen,
    input  logic [DATA_W-1:0]   lsu_req_wdata,
    input  logic [DATA_W/8-1:0] lsu_req_wmask,
    output logic                lsu_resp_valid,
    output logic [DATA_W-1:0]   lsu_resp_data,
    output logic                mem_req_valid,
    input  logic                mem_req_ready,
    output logic [ADDR_W-1:0]   mem_req_addr,
    output logic                mem_req_wen,
    output logic [DATA_W-1:0]   mem_req_wdata,
    output logic [DATA_W/8-1:0] mem_req_wmask,
    input  logic                mem_resp_valid,
    input  logic [DATA_W-1:0]   mem_resp_data,
    output logic                busy
);

    typedef enum logic [1:0] {StIdle, StReq, StResp} state_e;

    state_e                state_q, state_d;
    logic                  owner_q, owner_d;   // 0 = IFU, 1 = LSU
    logic [ADDR_W-1:0]     addr_q, addr_d;
    logic                  wen_q, wen_d;
    logic [DATA_W-1:0]     wdata_q, wdata_d;
    logic [DATA_W/8-1:0]   wmask_q, wmask_d;
    logic                  grant_lsu;

`ifdef MEM_ARB_RR_EN
    logic                  last_owner_q, last_owner_d;

    // On a tie, grant the requester that did not win last time.
    assign grant_lsu = lsu_req_valid && (!ifu_req_valid || !last_owner_q);
`else
    assign grant_lsu = lsu_req_valid;
`endif

    always_comb begin
        state_d        = state_q;
        owner_d        = owner_q;
        addr_d         = addr_q;
        wen_d          = wen_q;
        wdata_d        = wdata_q;
        wmask_d        = wmask_q;
        ifu_req_ready  = 1'b0;
        lsu_req_ready  = 1'b0;
        ifu_resp_valid = 1'b0;
        lsu_resp_valid = 1'b0;
        mem_req_valid  = 1'b0;
`ifdef MEM_ARB_RR_EN
        last_owner_d   = last_owner_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (grant_lsu) begin
                    lsu_req_ready = 1'b1;
                    owner_d       = 1'b1;
                    addr_d        = lsu_req_addr;
                    wen_d         = lsu_req_wen;
                    wdata_d       = lsu_req_wdata;
                    wmask_d       = lsu_req_wmask;
                    state_d       = StReq;
`ifdef MEM_ARB_RR_EN
                    last_owner_d  = 1'b1;
`endif
                end else if (ifu_req_valid) begin
                    ifu_req_ready = 1'b1;
                    owner_d       = 1'b0;
                    addr_d        = ifu_req_addr;
                    wen_d         = 1'b0;
                    wdata_d       = '0;
                    wmask_d       = '0;
                    state_d       = StReq;
`ifdef MEM_ARB_RR_EN
                    last_owner_d  = 1'b0;
`endif
                end
            end
            StReq: begin
                mem_req_valid = 1'b1;
                if (mem_req_ready) begin
                    state_d = StResp;
                end
            end
            StResp: begin
                // Stores complete on mem_resp_valid too; their data is ignored.
                if (mem_resp_valid) begin
                    ifu_resp_valid = !owner_q;
                    lsu_resp_valid = owner_q;
                    state_d        = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            owner_q      <= 1'b0;
            addr_q       <= '0;
            wen_q        <= 1'b0;
            wdata_q      <= '0;
            wmask_q      <= '0;
`ifdef MEM_ARB_RR_EN
            last_owner_q <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            addr_q       <= addr_d;
            wen_q        <= wen_d;
            wdata_q      <= wdata_d;
            wmask_q      <= wmask_d;
`ifdef MEM_ARB_RR_EN
            last_owner_q <= last_owner_d;
`endif
        end
    end

    assign mem_req_addr  = addr_q;
    assign mem_req_wen   = wen_q;
    assign mem_req_wdata = wdata_q;
    assign mem_req_wmask = wmask_q;
    // Response data is shared; only the valids are steered to the owner.
    assign ifu_resp_data = mem_resp_data;
    assign lsu_resp_data = mem_resp_data;
    assign busy          = (state_q != StIdle);

endmodule

// File: tb/tb_ysyx_23060203_mem_arb.sv
// Directed testbench for ysyx_23060203_mem_arb.
// Inputs are driven just after the falling edge. Outputs are sampled 1 ns later,
// which is well away from the rising edge.
module tb_ysyx_23060203_mem_arb;
    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          ifu_req_valid, ifu_req_ready, ifu_resp_valid;
    logic [AW-1:0] ifu_req_addr;
    logic [DW-1:0] ifu_resp_data;
    logic          lsu_req_valid, lsu_req_ready, lsu_req_wen, lsu_resp_valid;
    logic [AW-1:0] lsu_req_addr;
    logic [DW-1:0] lsu_req_wdata, lsu_resp_data;
    logic [DW/8-1:0] lsu_req_wmask;
    logic          mem_req_valid, mem_req_ready, mem_req_wen, mem_resp_valid;
    logic [AW-1:0] mem_req_addr;
    logic [DW-1:0] mem_req_wdata, mem_resp_data;
    logic [DW/8-1:0] mem_req_wmask;
    logic          busy;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    ysyx_23060203_mem_arb #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk            (clk),
        .rst            (rst),
        .ifu_req_valid  (ifu_req_valid),
        .ifu_req_ready  (ifu_req_ready),
        .ifu_req_addr   (ifu_req_addr),
        .ifu_resp_valid (ifu_resp_valid),
        .ifu_resp_data  (ifu_resp_data),
        .lsu_req_valid  (lsu_req_valid),
        .lsu_req_ready  (lsu_req_ready),
        .lsu_req_addr   (lsu_req_addr),
        .lsu_req_wen    (lsu_req_wen),
        .lsu_req_wdata  (lsu_req_wdata),
        .lsu_req_wmask  (lsu_req_wmask),
        .lsu_resp_valid (lsu_resp_valid),
        .lsu_resp_data  (lsu_resp_data),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_req_addr   (mem_req_addr),
        .mem_req_wen    (mem_req_wen),
        .mem_req_wdata  (mem_req_wdata),
        .mem_req_wmask  (mem_req_wmask),
        .mem_resp_valid (mem_resp_valid),
        .mem_resp_data  (mem_resp_data),
        .busy           (busy)
    );

    // Advance one clock and return just after the falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        ifu_req_valid  = 1'b0;
        ifu_req_addr   = '0;
        lsu_req_valid  = 1'b0;
        lsu_req_addr   = '0;
        lsu_req_wen    = 1'b0;
        lsu_req_wdata  = '0;
        lsu_req_wmask  = '0;
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
        mem_resp_data  = '0;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1'b1;
        tick();
        tick();
        #1;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b want 0", busy); end
        n_checks++; if (mem_req_valid !== 1'b0) begin n_fail++; $display("FAIL rst_mem_valid: got %b want 0", mem_req_valid); end
        n_checks++; if ({ifu_req_ready, lsu_req_ready, ifu_resp_valid, lsu_resp_valid} !== 4'b0) begin
            n_fail++; $display("FAIL rst_rdy_vld: got %b want 0000", {ifu_req_ready, lsu_req_ready, ifu_resp_valid, lsu_resp_valid}); end
        n_checks++; if ({mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wmask} !== '0) begin
            n_fail++; $display("FAIL rst_latched: got %h/%b/%h/%h want 0", mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wmask); end
        rst = 1'b0;
    endtask

    task automatic test_ifu_read();
        ifu_req_valid = 1'b1;
        ifu_req_addr  = 32'h8000_0000;
        #1;
        n_checks++; if (ifu_req_ready !== 1'b1) begin n_fail++; $display("FAIL ifu_rd_ready: got %b want 1", ifu_req_ready); end
        n_checks++; if (lsu_req_ready !== 1'b0) begin n_fail++; $display("FAIL ifu_rd_lsu_ready: got %b want 0", lsu_req_ready); end
        tick();
        ifu_req_valid = 1'b0;
        ifu_req_addr  = 32'h1234_5678;
        mem_req_ready = 1'b1;
        #1;
        n_checks++; if (mem_req_valid !== 1'b1) begin n_fail++; $display("FAIL ifu_rd_mem_valid: got %b want 1", mem_req_valid); end
        n_checks++; if (mem_req_addr !== 32'h8000_0000) begin n_fail++; $display("FAIL ifu_rd_addr: got %h want 80000000", mem_req_addr); end
        n_checks++; if ({mem_req_wen, mem_req_wmask} !== 5'b0) begin n_fail++; $display("FAIL ifu_rd_wen_mask: got %b/%h want 0/0", mem_req_wen, mem_req_wmask); end
        n_checks++; if (ifu_req_ready !== 1'b0) begin n_fail++; $display("FAIL ifu_rd_ready_req: got %b want 0", ifu_req_ready); end
        tick();
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b1;
        mem_resp_data  = 32'h0010_0093;
        #1;
        n_checks++; if (ifu_resp_valid !== 1'b1) begin n_fail++; $display("FAIL ifu_rd_resp_valid: got %b want 1", ifu_resp_valid); end
        n_checks++; if (ifu_resp_data !== 32'h0010_0093) begin n_fail++; $display("FAIL ifu_rd_resp_data: got %h want 00100093", ifu_resp_data); end
        n_checks++; if (lsu_resp_valid !== 1'b0) begin n_fail++; $display("FAIL ifu_rd_lsu_resp: got %b want 0", lsu_resp_valid); end
        n_checks++; if (mem_req_valid !== 1'b0) begin n_fail++; $display("FAIL ifu_rd_mem_valid_resp: got %b want 0", mem_req_valid); end
        tick();
        mem_resp_valid = 1'b0;
        #1;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL ifu_rd_idle: got busy %b want 0", busy); end
    endtask

    task automatic test_lsu_store();
        lsu_req_valid = 1'b1;
        lsu_req_addr  = 32'h8000_1000;
        lsu_req_wen   = 1'b1;
        lsu_req_wdata = 32'hDEAD_BEEF;
        lsu_req_wmask = 4'hF;
        #1;
        n_checks++; if (lsu_req_ready !== 1'b1) begin n_fail++; $display("FAIL st_ready: got %b want 1", lsu_req_ready); end
        tick();
        // Scramble the inputs; the latched copy must not follow them.
        lsu_req_valid = 1'b0;
        lsu_req_addr  = 32'h0;
        lsu_req_wen   = 1'b0;
        lsu_req_wdata = 32'h0;
        lsu_req_wmask = 4'h0;
        for (int i = 0; i < 4; i++) begin
            mem_req_ready = (i == 3);
            #1;
            n_checks++; if ({mem_req_valid, mem_req_wen, busy} !== 3'b111) begin
                n_fail++; $display("FAIL st_req_vld_wen_busy[%0d]: got %b want 111", i, {mem_req_valid, mem_req_wen, busy}); end
            n_checks++; if ({mem_req_addr, mem_req_wdata, mem_req_wmask} !== {32'h8000_1000, 32'hDEAD_BEEF, 4'hF}) begin
                n_fail++; $display("FAIL st_req_fields[%0d]: got %h/%h/%h want 80001000/deadbeef/f", i, mem_req_addr, mem_req_wdata, mem_req_wmask); end
            tick();
        end
        mem_req_ready = 1'b0;
        #1;
        n_checks++; if ({lsu_resp_valid, busy, mem_req_valid} !== 3'b010) begin
            n_fail++; $display("FAIL st_wait_resp: got %b want 010", {lsu_resp_valid, busy, mem_req_valid}); end
        tick();
        mem_resp_valid = 1'b1;
        mem_resp_data  = 32'h5555_AAAA;
        #1;
        n_checks++; if ({lsu_resp_valid, ifu_resp_valid, busy} !== 3'b101) begin
            n_fail++; $display("FAIL st_resp: got %b want 101", {lsu_resp_valid, ifu_resp_valid, busy}); end
        tick();
        mem_resp_valid = 1'b0;
        #1;
        n_checks++; if ({lsu_resp_valid, busy} !== 2'b00) begin
            n_fail++; $display("FAIL st_done: got %b want 00", {lsu_resp_valid, busy}); end
    endtask

    task automatic test_priority();
        ifu_req_valid = 1'b1;
        ifu_req_addr  = 32'h8000_0004;
        lsu_req_valid = 1'b1;
        lsu_req_addr  = 32'h8000_2000;
        lsu_req_wen   = 1'b0;
        #1;
        n_checks++; if ({lsu_req_ready, ifu_req_ready} !== 2'b10) begin
            n_fail++; $display("FAIL prio_first_grant: got lsu/ifu %b want 10", {lsu_req_ready, ifu_req_ready}); end
        tick();
        lsu_req_valid = 1'b0;
        mem_req_ready = 1'b1;
        #1;
        n_checks++; if (ifu_req_ready !== 1'b0) begin n_fail++; $display("FAIL prio_ifu_wait: got %b want 0", ifu_req_ready); end
        n_checks++; if (mem_req_addr !== 32'h8000_2000) begin n_fail++; $display("FAIL prio_lsu_addr: got %h want 80002000", mem_req_addr); end
        tick();
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b1;
        #1;
        n_checks++; if ({lsu_resp_valid, ifu_resp_valid, ifu_req_ready} !== 3'b100) begin
            n_fail++; $display("FAIL prio_lsu_resp: got %b want 100", {lsu_resp_valid, ifu_resp_valid, ifu_req_ready}); end
        tick();
        mem_resp_valid = 1'b0;
        #1;
        n_checks++; if ({ifu_req_ready, lsu_req_ready} !== 2'b10) begin
            n_fail++; $display("FAIL prio_ifu_grant: got ifu/lsu %b want 10", {ifu_req_ready, lsu_req_ready}); end
        tick();
        ifu_req_valid = 1'b0;
        mem_req_ready = 1'b1;
        #1;
        n_checks++; if (mem_req_addr !== 32'h8000_0004) begin n_fail++; $display("FAIL prio_ifu_addr: got %h want 80000004", mem_req_addr); end
        tick();
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b1;
        #1;
        n_checks++; if ({ifu_resp_valid, lsu_resp_valid} !== 2'b10) begin
            n_fail++; $display("FAIL prio_ifu_resp: got ifu/lsu %b want 10", {ifu_resp_valid, lsu_resp_valid}); end
        tick();
        mem_resp_valid = 1'b0;
    endtask

    // Four back-to-back ties with both requesters held valid throughout.
    task automatic test_back_to_back_ties();
        logic exp_lsu;
        clear_inputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        ifu_req_valid = 1'b1;
        ifu_req_addr  = 32'h8000_0100;
        lsu_req_valid = 1'b1;
        lsu_req_addr  = 32'h8000_3000;
        for (int k = 0; k < 4; k++) begin
`ifdef MEM_ARB_RR_EN
            exp_lsu = ((k % 2) == 0);
`else
            exp_lsu = 1'b1;
`endif
            #1;
            n_checks++; if ({lsu_req_ready, ifu_req_ready} !== {exp_lsu, !exp_lsu}) begin
                n_fail++; $display("FAIL tie_grant[%0d]: got lsu/ifu %b want %b", k, {lsu_req_ready, ifu_req_ready}, {exp_lsu, !exp_lsu}); end
            tick();
            mem_req_ready = 1'b1;
            #1;
            n_checks++; if (mem_req_addr !== (exp_lsu ? 32'h8000_3000 : 32'h8000_0100)) begin
                n_fail++; $display("FAIL tie_addr[%0d]: got %h want %h", k, mem_req_addr, exp_lsu ? 32'h8000_3000 : 32'h8000_0100); end
            tick();
            mem_req_ready  = 1'b0;
            mem_resp_valid = 1'b1;
            #1;
            n_checks++; if ({lsu_resp_valid, ifu_resp_valid} !== {exp_lsu, !exp_lsu}) begin
                n_fail++; $display("FAIL tie_resp[%0d]: got lsu/ifu %b want %b", k, {lsu_resp_valid, ifu_resp_valid}, {exp_lsu, !exp_lsu}); end
            tick();
            mem_resp_valid = 1'b0;
        end
        clear_inputs();
        tick();
    endtask

    task automatic test_spurious_resp();
        mem_resp_valid = 1'b1;
        #1;
        n_checks++; if ({ifu_resp_valid, lsu_resp_valid, busy} !== 3'b000) begin
            n_fail++; $display("FAIL spur_idle: got %b want 000", {ifu_resp_valid, lsu_resp_valid, busy}); end
        tick();
        #1;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL spur_idle_stay: got busy %b want 0", busy); end
        ifu_req_valid = 1'b1;
        ifu_req_addr  = 32'h8000_0200;
        mem_resp_valid = 1'b0;
        tick();
        ifu_req_valid  = 1'b0;
        mem_resp_valid = 1'b1;
        #1;
        n_checks++; if ({ifu_resp_valid, lsu_resp_valid, mem_req_valid} !== 3'b001) begin
            n_fail++; $display("FAIL spur_req: got %b want 001", {ifu_resp_valid, lsu_resp_valid, mem_req_valid}); end
        tick();
        mem_resp_valid = 1'b0;
        mem_req_ready  = 1'b1;
        #1;
        n_checks++; if (mem_req_valid !== 1'b1) begin n_fail++; $display("FAIL spur_req_stay: got %b want 1", mem_req_valid); end
        tick();
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b1;
        #1;
        n_checks++; if (ifu_resp_valid !== 1'b1) begin n_fail++; $display("FAIL spur_final_resp: got %b want 1", ifu_resp_valid); end
        tick();
        mem_resp_valid = 1'b0;
    endtask

    task automatic test_reset_mid_txn();
        ifu_req_valid = 1'b1;
        ifu_req_addr  = 32'h8000_0300;
        tick();
        ifu_req_valid = 1'b0;
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        #1;
        n_checks++; if ({busy, mem_req_valid} !== 2'b10) begin
            n_fail++; $display("FAIL rmid_in_resp: got %b want 10", {busy, mem_req_valid}); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        n_checks++; if ({busy, ifu_req_ready, lsu_req_ready, mem_req_valid} !== 4'b0) begin
            n_fail++; $display("FAIL rmid_idle: got %b want 0000", {busy, ifu_req_ready, lsu_req_ready, mem_req_valid}); end
        mem_resp_valid = 1'b1;
        #1;
        n_checks++; if ({ifu_resp_valid, lsu_resp_valid} !== 2'b00) begin
            n_fail++; $display("FAIL rmid_late_resp: got %b want 00", {ifu_resp_valid, lsu_resp_valid}); end
        tick();
        mem_resp_valid = 1'b0;
        ifu_req_valid  = 1'b1;
        ifu_req_addr   = 32'h8000_0400;
        #1;
        n_checks++; if (ifu_req_ready !== 1'b1) begin n_fail++; $display("FAIL rmid_new_ready: got %b want 1", ifu_req_ready); end
        tick();
        ifu_req_valid = 1'b0;
        mem_req_ready = 1'b1;
        #1;
        n_checks++; if (mem_req_addr !== 32'h8000_0400) begin n_fail++; $display("FAIL rmid_new_addr: got %h want 80000400", mem_req_addr); end
        tick();
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b1;
        mem_resp_data  = 32'hCAFE_F00D;
        #1;
        n_checks++; if ({ifu_resp_valid, ifu_resp_data} !== {1'b1, 32'hCAFE_F00D}) begin
            n_fail++; $display("FAIL rmid_new_resp: got %b/%h want 1/cafef00d", ifu_resp_valid, ifu_resp_data); end
        tick();
        mem_resp_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        clear_inputs();
        rst = 1'b1;
        @(negedge clk);
        test_reset();
        test_ifu_read();
        test_lsu_store();
        test_priority();
        test_back_to_back_ties();
        test_spurious_resp();
        test_reset_mid_txn();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
